// File: rtl/rx_fifo.sv
// ----------------------------------------------------------------------------
// rx_fifo : receive-side byte buffer placed directly after the UART receiver.
//
// Each byte the receiver presents with its one-cycle done pulse is captured
// into a circular buffer. The host pops bytes at its own pace. The buffer
// reports occupancy, an almost-full level, and a sticky overflow flag.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   rx_done_tick  in   one-cycle write strobe from the receiver
//   din[7:0]      in   received byte, sampled with rx_done_tick
//   rd            in   pop request from the consumer
//   dout[7:0]     out  head byte (first-word-fall-through)
//   empty         out  no bytes stored
//   full          out  2**ADDR_W bytes stored
//   almost_full   out  count >= AF_LEVEL
//   count         out  number of stored bytes, 0..2**ADDR_W
//   overflow      out  sticky: at least one byte was dropped
//   clr_overflow  in   clears overflow (a same-cycle drop takes priority)
// ----------------------------------------------------------------------------
module rx_fifo #(
   parameter int ADDR_W   = 4,
   parameter int AF_LEVEL = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_done_tick,
   input  logic [7:0]        din,
   input  logic              rd,
   output logic [7:0]        dout,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   input  logic              clr_overflow
);

   localparam int              DEPTH   = 2**ADDR_W;
   localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] C_AF    = (ADDR_W+1)'(AF_LEVEL);

   logic [7:0]        r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_overflow;

   logic w_empty;
   logic w_full;
   logic w_rd_acc;
   logic w_wr_acc;
   logic w_drop;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == C_DEPTH);

   // A read is only honoured when something is stored, so a write into an
   // empty buffer is never popped in the same cycle. When full, a same-cycle
   // read frees the slot the write needs, so both are accepted.
   assign w_rd_acc = rd & ~w_empty;
   assign w_wr_acc = rx_done_tick & (~w_full | w_rd_acc);
   assign w_drop   = rx_done_tick & ~w_wr_acc;

   // Storage has no reset: contents are meaningless while empty.
   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // Drop has priority over clear so a lost byte is never hidden.
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (clr_overflow) begin
            r_overflow <= 1'b0;
         end
      end
   end

   assign dout        = r_mem[r_rd_ptr];
   assign empty       = w_empty;
   assign full        = w_full;
   assign almost_full = (r_count >= C_AF);
   assign count       = r_count;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_rx_fifo : directed and randomized stimulus for rx_fifo, compared against
// a queue-based reference model of the buffer.
// ----------------------------------------------------------------------------
module tb_rx_fifo;

   localparam int ADDR_W   = 4;
   localparam int AF_LEVEL = 12;
   localparam int DEPTH    = 2**ADDR_W;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            rx_done_tick = 1'b0;
   logic [7:0]      din = 8'h00;
   logic            rd = 1'b0;
   logic [7:0]      dout;
   logic            empty;
   logic            full;
   logic            almost_full;
   logic [ADDR_W:0] count;
   logic            overflow;
   logic            clr_overflow = 1'b0;

   int checks   = 0;
   int failures = 0;

   // reference model
   logic [7:0] q[$];
   logic       m_ovf = 1'b0;

   rx_fifo #(.ADDR_W(ADDR_W), .AF_LEVEL(AF_LEVEL)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_done_tick (rx_done_tick),
      .din          (din),
      .rd           (rd),
      .dout         (dout),
      .empty        (empty),
      .full         (full),
      .almost_full  (almost_full),
      .count        (count),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("count", 32'(count), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(q.size() >= AF_LEVEL));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (q.size() != 0) chk("dout", 32'(dout), 32'(q[0]));
   endtask

   task automatic model_step(input logic w, input logic [7:0] d, input logic r, input logic c);
      int  n;
      bit  ra, wa;
      n  = q.size();
      ra = r && (n != 0);
      wa = w && ((n < DEPTH) || ra);
      if (ra) void'(q.pop_front());
      if (wa) q.push_back(d);
      if (w && !wa) m_ovf = 1'b1;
      else if (c)   m_ovf = 1'b0;
   endtask

   task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
      rx_done_tick = w; din = d; rd = r; clr_overflow = c;
      @(posedge clk);
      model_step(w, d, r, c);
      #1;
      rx_done_tick = 1'b0; rd = 1'b0; clr_overflow = 1'b0;
      check_all();
   endtask

   initial begin
      logic [7:0] nxt;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_all();
      reset = 1'b0;

      // 1: single byte in and out
      cyc(1'b1, 8'hA5, 1'b0, 1'b0);
      chk("t1_dout", 32'(dout), 32'h A5);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t1_empty", 32'(empty), 32'd1);

      // 2: fill 0x00..0x0F, then drain in order
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
      chk("t2_full", 32'(full), 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         chk("t2_order", 32'(dout), 32'(i));
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("t2_empty", 32'(empty), 32'd1);

      // 3: overflow set, clear, and drop-wins-over-clear
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'($urandom_range(0, 8'hED)), 1'b0, 1'b0);
      cyc(1'b1, 8'hEE, 1'b0, 1'b0);
      chk("t3_ovf_set", 32'(overflow), 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t3_ovf_clr", 32'(overflow), 32'd0);
      cyc(1'b1, 8'hEE, 1'b0, 1'b1);
      chk("t3_ovf_prio", 32'(overflow), 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);

      // 4: simultaneous write+read while full
      cyc(1'b1, 8'h55, 1'b1, 1'b0);
      chk("t4_count", 32'(count), 32'(DEPTH));
      chk("t4_ovf", 32'(overflow), 32'd0);
      for (int i = 0; i < DEPTH - 1; i++) begin
         chk("t4_no_ee", 32'(dout == 8'hEE), 32'd0);
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("t4_dout55", 32'(dout), 32'h55);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);

      // 5: simultaneous write+read while empty, then read on empty
      cyc(1'b1, 8'h3C, 1'b1, 1'b0);
      chk("t5_count", 32'(count), 32'd1);
      chk("t5_dout", 32'(dout), 32'h3C);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t5_rd_empty", 32'(count), 32'd0);

      // 6a: 40 bytes through a shallow occupancy, across pointer wrap
      nxt = 8'h10;
      for (int i = 0; i < 40; i++) begin
         logic r;
         if (q.size() >= 5)      r = 1'b1;
         else if (q.size() >= 1) r = 1'($urandom_range(0, 1));
         else                    r = 1'b0;
         if (r) begin
            chk("t6_order", 32'(dout), 32'(nxt));
            nxt++;
         end
         cyc(1'b1, 8'(8'h10 + i), r, 1'b0);
      end
      while (q.size() != 0) begin
         chk("t6_order", 32'(dout), 32'(nxt));
         nxt++;
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("t6_all_read", 32'(nxt), 32'h38);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45),
             1'($urandom_range(0, 99) < 5));
      end

      // 6b: reset mid-stream at count=3 with overflow set
      while (q.size() < DEPTH) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
      cyc(1'b1, 8'h99, 1'b0, 1'b0);
      while (q.size() > 3) cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t6_pre_ovf", 32'(overflow), 32'd1);
      reset = 1'b1;
      #1;
      q.delete();
      m_ovf = 1'b0;
      chk("t6_rst_count", 32'(count), 32'd0);
      chk("t6_rst_empty", 32'(empty), 32'd1);
      chk("t6_rst_ovf", 32'(overflow), 32'd0);
      #2;
      reset = 1'b0;
      cyc(1'b1, 8'h42, 1'b0, 1'b0);
      chk("t6_after_rst", 32'(dout), 32'h42);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rx_fifo.md
Name: rx_fifo

Overview:
- Receive-side byte buffer that sits directly downstream of the UART receiver.
- Captures each byte the receiver presents with its one-cycle done pulse and holds it in a circular FIFO until the host logic pops it.
- Reports occupancy, a programmable almost-full level, and a sticky overflow flag, so that bytes arriving while the host is busy are not silently lost.

Parameters:
- ADDR_W, 4, log2 of FIFO depth; depth = 2**ADDR_W (default 16 entries).
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; legal range 1..2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_done_tick  in  1  one-cycle write strobe from the receiver.
- din  in  8  received byte; valid only while rx_done_tick=1.
- rd  in  1  pop request from the consumer.
- dout  out  8  byte at the FIFO head (first-word-fall-through).
- empty  out  1  FIFO holds no bytes.
- full  out  1  FIFO holds 2**ADDR_W bytes.
- almost_full  out  1  count >= AF_LEVEL.
- count  out  ADDR_W+1  number of stored bytes, 0..2**ADDR_W.
- overflow  out  1  sticky flag: at least one byte dropped.
- clr_overflow  in  1  clears overflow.

Behaviour:
- Reset (async, active-high):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, almost_full=0, overflow=0.
  - Storage contents are don't-care; dout is don't-care while empty=1.
- Storage and pointers:
  - Storage is 2**ADDR_W x 8 bits.
  - wr_ptr and rd_ptr are ADDR_W bits wide and wrap naturally from 2**ADDR_W-1 to 0.
  - count is an explicit ADDR_W+1-bit register.
  - empty = (count==0); full = (count==2**ADDR_W); almost_full = (count>=AF_LEVEL). All three are derived from registered count, so they are glitch-free and valid in the cycle after the update.
- dout:
  - dout = mem[rd_ptr], a combinational read of the head entry.
  - Valid whenever empty=0; the head byte is visible in the cycle after its write edge.
- Write event (rx_done_tick=1):
  - If not full, or full with a read accepted in the same cycle: mem[wr_ptr] <= din, wr_ptr+1.
  - If full with no read: byte dropped, pointers unchanged, overflow <= 1.
- Read event (rd=1):
  - If empty=0: rd_ptr+1.
  - If empty=1: ignored; no pointer change, no error flag.
- Count update per cycle:
  - Accepted write only: +1.
  - Accepted read only: -1.
  - Both accepted: unchanged.
  - Neither: unchanged.
- Simultaneous write and read:
  - When empty: only the write is accepted; count becomes 1, and the new byte is not popped.
  - When full: both are accepted; count stays full and overflow is not set.
  - Otherwise: both accepted, count unchanged.
- overflow:
  - Set by any dropped write.
  - Cleared by clr_overflow=1.
  - If a drop and clr_overflow occur in the same cycle, set wins (overflow=1).
- No other state machine is required. Control is a two-event decoder {write_accepted, read_accepted} applied to pointers and count.
- Reset mid-operation: all bytes are discarded immediately; flags return to reset values asynchronously.
- Latency:
  - Write to visible on dout/empty: 1 cycle.
  - rd to next head on dout: 1 cycle.

Test Plan:
1. Reset, then write 0xA5 with one rx_done_tick pulse -> next cycle empty=0, count=1, dout=0xA5. Then rd=1 for one cycle -> empty=1, count=0.
2. Write 16 bytes 0x00..0x0F with no reads (ADDR_W=4, AF_LEVEL=12):
   - almost_full=1 once count=12.
   - full=1 at count=16.
   - Then pop all 16 -> dout sequence 0x00..0x0F in order; empty=1 at the end.
3. Fill to full, then write 0xEE with rd=0 -> overflow=1, count stays 16, and 0xEE never appears on dout. Then clr_overflow=1 -> overflow=0. Drop and clr_overflow in the same cycle -> overflow=1.
4. Full FIFO, rx_done_tick=1 with din=0x55 and rd=1 in the same cycle:
   - count stays 16, overflow stays 0.
   - After 15 further pops, dout=0x55.
5. Empty FIFO, rx_done_tick=1 with din=0x3C and rd=1 in the same cycle -> count=1, dout=0x3C. Then rd on the empty FIFO after popping is ignored (count stays 0, no flag).
6. Wrap-around and reset:
   - Repeated write/pop of 40 bytes 0x10..0x37 with occupancy between 1 and 5 -> all bytes are read back in order across pointer wrap.
   - Assert reset mid-stream with count=3 -> immediately count=0, empty=1, overflow=0.
